// File: rtl/ofs_plat_avalon_mem_rr_mux_if.sv
// ofs_plat_avalon_mem_rr_mux_if: AFU-side port bundle plus FIU-side bus of the round-robin mux.
interface ofs_plat_avalon_mem_rr_mux_if #(
   parameter int NUM_PORTS = 2,
   parameter int ADDR_WIDTH = 42,
   parameter int DATA_WIDTH = 512,
   parameter int BURST_CNT_WIDTH = 7
);
   logic [NUM_PORTS*ADDR_WIDTH-1:0] in_address;
   logic [NUM_PORTS-1:0] in_read;
   logic [NUM_PORTS-1:0] in_write;
   logic [NUM_PORTS*BURST_CNT_WIDTH-1:0] in_burstcount;
   logic [NUM_PORTS*DATA_WIDTH-1:0] in_writedata;
   logic [NUM_PORTS*DATA_WIDTH/8-1:0] in_byteenable;
   logic [NUM_PORTS-1:0] in_waitrequest;
   logic [DATA_WIDTH-1:0] in_readdata;
   logic [NUM_PORTS-1:0] in_readdatavalid;
   logic [ADDR_WIDTH-1:0] out_address;
   logic out_read;
   logic out_write;
   logic [BURST_CNT_WIDTH-1:0] out_burstcount;
   logic [DATA_WIDTH-1:0] out_writedata;
   logic [DATA_WIDTH/8-1:0] out_byteenable;
   logic out_waitrequest;
   logic [DATA_WIDTH-1:0] out_readdata;
   logic out_readdatavalid;
   modport slave (
      input  in_address, in_read, in_write, in_burstcount, in_writedata, in_byteenable,
      output in_waitrequest, in_readdata, in_readdatavalid,
      output out_address, out_read, out_write, out_burstcount, out_writedata, out_byteenable,
      input  out_waitrequest, out_readdata, out_readdatavalid
   );
   modport master (
      output in_address, in_read, in_write, in_burstcount, in_writedata, in_byteenable,
      input  in_waitrequest, in_readdata, in_readdatavalid,
      input  out_address, out_read, out_write, out_burstcount, out_writedata, out_byteenable,
      output out_waitrequest, out_readdata, out_readdatavalid
   );
endinterface

// File: rtl/ofs_plat_avalon_mem_rr_mux.sv
// ofs_plat_avalon_mem_rr_mux: round-robin merge of NUM_PORTS Avalon-MM masters onto one FIU master,
// with write-burst locking and in-order read-response routing through a tag FIFO.
module ofs_plat_avalon_mem_rr_mux #(
   parameter int NUM_PORTS = 2,
   parameter int ADDR_WIDTH = 42,
   parameter int DATA_WIDTH = 512,
   parameter int BURST_CNT_WIDTH = 7,
   parameter int MAX_RD_OUTSTANDING = 64
) (
   input  logic clk,
   input  logic reset,
   ofs_plat_avalon_mem_rr_mux_if.slave bus,
   output logic rsp_err
);
   localparam int PW = $clog2(NUM_PORTS);
   localparam int FW = $clog2(MAX_RD_OUTSTANDING);
   localparam int BW = BURST_CNT_WIDTH;
   localparam int EW = DATA_WIDTH/8;
   typedef enum logic {IDLE_ARB, WR_LOCK} state_t;
   state_t state_q, state_d;
   logic [PW-1:0] rr_ptr_q, rr_ptr_d, lock_port_q, lock_port_d, grant, grant_nxt;
   logic [BW-1:0] beats_left_q, beats_left_d, head_done_q;
   logic rst_hold_q, rsp_err_q, any_elig, accept, push, pop, rsp_ok;
   logic [NUM_PORTS-1:0] eligible, rdv_q;
   logic [PW-1:0] fifo_port_q [MAX_RD_OUTSTANDING];
   logic [BW-1:0] fifo_bc_q [MAX_RD_OUTSTANDING];
   logic [FW-1:0] wr_ptr_q, rd_ptr_q;
   logic [FW:0] count_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   // Reverse scan so the last hit is the first eligible port at or after rr_ptr.
   always_comb begin
      eligible = bus.in_write | (bus.in_read & {NUM_PORTS{count_q != (FW+1)'(MAX_RD_OUTSTANDING)}});
      grant = lock_port_q;
      any_elig = 1'b0;
      if (state_q == WR_LOCK) any_elig = eligible[lock_port_q];
      else
         for (int i = NUM_PORTS-1; i >= 0; i--)
            if (eligible[PW'((int'(rr_ptr_q) + i) % NUM_PORTS)]) begin
               grant = PW'((int'(rr_ptr_q) + i) % NUM_PORTS);
               any_elig = 1'b1;
            end
      any_elig = any_elig & !reset & !rst_hold_q;
   end
   assign grant_nxt = (grant == PW'(NUM_PORTS-1)) ? '0 : grant + PW'(1);
   assign accept = any_elig & !bus.out_waitrequest;
   assign push = accept & bus.in_read[grant];
   assign rsp_ok = bus.out_readdatavalid & (count_q != '0);
   assign pop = rsp_ok & (head_done_q + BW'(1) == fifo_bc_q[rd_ptr_q]);
   assign bus.out_address = bus.in_address[grant*ADDR_WIDTH +: ADDR_WIDTH];
   assign bus.out_burstcount = bus.in_burstcount[grant*BW +: BW];
   assign bus.out_writedata = bus.in_writedata[grant*DATA_WIDTH +: DATA_WIDTH];
   assign bus.out_byteenable = bus.in_byteenable[grant*EW +: EW];
   assign bus.out_read = any_elig & bus.in_read[grant];
   assign bus.out_write = any_elig & bus.in_write[grant];
   assign bus.in_waitrequest = ~(NUM_PORTS'(accept) << grant);
   assign bus.in_readdata = rdata_q;
   assign bus.in_readdatavalid = rdv_q;
   assign rsp_err = rsp_err_q;
   always_comb begin
      state_d = state_q;
      rr_ptr_d = rr_ptr_q;
      lock_port_d = lock_port_q;
      beats_left_d = beats_left_q;
      if (accept && state_q == WR_LOCK) begin
         beats_left_d = beats_left_q - BW'(1);
         state_d = (beats_left_q == BW'(1)) ? IDLE_ARB : WR_LOCK;
         rr_ptr_d = (beats_left_q == BW'(1)) ? grant_nxt : rr_ptr_q;
      end else if (accept && (bus.in_read[grant] || bus.out_burstcount == BW'(1))) rr_ptr_d = grant_nxt;
      else if (accept) begin
         state_d = WR_LOCK;
         lock_port_d = grant;
         beats_left_d = bus.out_burstcount - BW'(1);
      end
   end
   always_ff @(posedge clk) begin
      rst_hold_q <= reset;
      if (reset) begin
         state_q <= IDLE_ARB;
         rr_ptr_q <= '0;
         lock_port_q <= '0;
         beats_left_q <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q <= '0;
         head_done_q <= '0;
         rdv_q <= '0;
         rdata_q <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_ptr_q <= rr_ptr_d;
         lock_port_q <= lock_port_d;
         beats_left_q <= beats_left_d;
         wr_ptr_q <= push ? wr_ptr_q + FW'(1) : wr_ptr_q;
         rd_ptr_q <= pop ? rd_ptr_q + FW'(1) : rd_ptr_q;
         count_q <= count_q + (FW+1)'(push) - (FW+1)'(pop);
         head_done_q <= pop ? '0 : head_done_q + BW'(rsp_ok);
         rdv_q <= rsp_ok ? NUM_PORTS'(1) << fifo_port_q[rd_ptr_q] : '0;
         rdata_q <= rsp_ok ? bus.out_readdata : rdata_q;
         rsp_err_q <= rsp_err_q | (bus.out_readdatavalid & (count_q == '0));
      end
   end
   always_ff @(posedge clk)
      if (push) begin
         fifo_port_q[wr_ptr_q] <= grant;
         fifo_bc_q[wr_ptr_q] <= bus.out_burstcount;
      end
endmodule
